// File: rtl/cbfp_block_scaler_if.sv
// Stream bundle for cbfp_block_scaler: input beat handshake plus normalised output beat with exponent/framing.
// slave is the scaler's view, master is the view of whoever feeds and drains it.
interface cbfp_block_scaler_if #(
  parameter int IN_W  = 25,
  parameter int OUT_W = 12,
  parameter int LANES = 8,
  parameter int CH    = 4,
  parameter int EXP_W = 5
);
  logic                        s_valid;
  logic                        s_ready;
  logic [CH*LANES*IN_W-1:0]    s_data;
  logic                        m_valid;
  logic                        m_ready;
  logic [CH*LANES*OUT_W-1:0]   m_data;
  logic [EXP_W-1:0]            m_exp;
  logic                        m_first;
  logic                        m_last;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_exp, m_first, m_last
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_exp, m_first, m_last
  );
endinterface

// File: rtl/cbfp_block_scaler.sv
// Convergent block-floating-point stage: buffers a block, finds the common shift, drains it normalised.
// Define CBFP_ROUND_EN for round-half-up with saturation and one extra output register stage.
module cbfp_block_scaler #(
  parameter int IN_W  = 25,
  parameter int OUT_W = 12,
  parameter int LANES = 8,
  parameter int CH    = 4,
  parameter int BEATS = 4,
  parameter int EXP_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  cbfp_block_scaler_if.slave   bus
);

  localparam int N     = CH * LANES;
  localparam int SH    = IN_W - OUT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [EXP_W-1:0] MAX_RSB   = EXP_W'(IN_W - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic [1:0]         state;
  logic [CNT_W-1:0]   beat_cnt;
  logic [EXP_W-1:0]   run_min;
  logic [EXP_W-1:0]   beat_min;
  logic [EXP_W-1:0]   exp_q;
  logic [N*IN_W-1:0]  buffer [BEATS];
  logic [N*OUT_W-1:0] scaled;
  logic signed [IN_W-1:0] t;
  logic               s_fire;
  logic               d_fire;
  logic               drain_last;

  // Count of bits below the MSB that repeat it, stopping at the first differing bit.
  function automatic logic [EXP_W-1:0] rsb(input logic [IN_W-1:0] x);
    logic [EXP_W-1:0] cnt;
    logic             done;
    cnt  = '0;
    done = 1'b0;
    for (int i = IN_W - 2; i >= 0; i--) begin
      if (!done) begin
        if (x[i] == x[IN_W-1]) cnt = cnt + EXP_W'(1);
        else                   done = 1'b1;
      end
    end
    return cnt;
  endfunction

  always_comb begin
    beat_min = MAX_RSB;
    for (int i = 0; i < N; i++) begin
      if (rsb(bus.s_data[i*IN_W +: IN_W]) < beat_min) beat_min = rsb(bus.s_data[i*IN_W +: IN_W]);
    end
  end

  assign s_fire     = bus.s_valid && bus.s_ready;
  assign drain_last = (beat_cnt == LAST_BEAT);

`ifdef CBFP_ROUND_EN
  logic signed [IN_W:0]  rnd;
  logic signed [OUT_W:0] q;
  localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1 << (SH - 1));

  // The extra sign bit in rnd absorbs the rounding carry; only the top end can then exceed the output range.
  always_comb begin
    scaled = '0;
    t      = '0;
    rnd    = '0;
    q      = '0;
    for (int i = 0; i < N; i++) begin
      t   = $signed(buffer[beat_cnt][i*IN_W +: IN_W]) <<< exp_q;
      rnd = $signed({t[IN_W-1], t}) + HALF;
      q   = (OUT_W+1)'(rnd >>> SH);
      if (!q[OUT_W] && q[OUT_W-1])      scaled[i*OUT_W +: OUT_W] = {1'b0, {(OUT_W-1){1'b1}}};
      else if (q[OUT_W] && !q[OUT_W-1]) scaled[i*OUT_W +: OUT_W] = {1'b1, {(OUT_W-1){1'b0}}};
      else                              scaled[i*OUT_W +: OUT_W] = q[OUT_W-1:0];
    end
  end

  logic               out_valid;
  logic [N*OUT_W-1:0] out_data;
  logic               out_first;
  logic               out_last;

  // The output register refills whenever it is empty or being consumed this cycle.
  assign d_fire = (state == DRAIN) && (!out_valid || bus.m_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else if (d_fire) begin
      out_valid <= 1'b1;
      out_data  <= scaled;
      out_first <= (beat_cnt == '0);
      out_last  <= drain_last;
    end else if (bus.m_ready) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  // Holding off the next block until the final beat leaves keeps m_exp stable for it.
  assign bus.s_ready = (state == FILL) && !out_valid;
  assign bus.m_valid = out_valid;
  assign bus.m_data  = out_data;
  assign bus.m_first = out_first;
  assign bus.m_last  = out_last;
`else
  // Shifting by the block minimum never overflows, so narrowing is a plain floor of the top bits.
  always_comb begin
    scaled = '0;
    t      = '0;
    for (int i = 0; i < N; i++) begin
      t = $signed(buffer[beat_cnt][i*IN_W +: IN_W]) <<< exp_q;
      scaled[i*OUT_W +: OUT_W] = OUT_W'(t >>> SH);
    end
  end

  assign d_fire      = (state == DRAIN) && bus.m_ready;
  assign bus.s_ready = (state == FILL);
  assign bus.m_valid = (state == DRAIN);
  assign bus.m_data  = (state == DRAIN) ? scaled : '0;
  assign bus.m_first = (state == DRAIN) && (beat_cnt == '0);
  assign bus.m_last  = (state == DRAIN) && drain_last;
`endif

  assign bus.m_exp = exp_q;

  always_ff @(posedge clk) begin
    if (s_fire) buffer[beat_cnt] <= bus.s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      beat_cnt <= '0;
      run_min  <= MAX_RSB;
      exp_q    <= '0;
    end else begin
      case (state)
        FILL: begin
          if (s_fire) begin
            if (beat_min < run_min) run_min <= beat_min;
            if (drain_last) begin
              beat_cnt <= '0;
              state    <= CALC;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        CALC: begin
          exp_q   <= run_min;
          run_min <= MAX_RSB;
          state   <= DRAIN;
        end
        DRAIN: begin
          if (d_fire) begin
            if (drain_last) begin
              beat_cnt <= '0;
              state    <= FILL;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_cbfp_block_scaler.sv
// Randomised self-checking bench for cbfp_block_scaler against an arithmetic block-floating-point model.
// Compile with CBFP_ROUND_EN defined to check the rounding/saturating variant.
module tb_cbfp_block_scaler;

  localparam int IN_W  = 25;
  localparam int OUT_W = 12;
  localparam int LANES = 8;
  localparam int CH    = 4;
  localparam int BEATS = 4;
  localparam int EXP_W = 5;
  localparam int N     = CH * LANES;
  localparam int SH    = IN_W - OUT_W;
`ifdef CBFP_ROUND_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cbfp_block_scaler_if #(.IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES), .CH(CH), .EXP_W(EXP_W)) bus ();

  cbfp_block_scaler #(
    .IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES), .CH(CH), .BEATS(BEATS), .EXP_W(EXP_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  longint             stim      [BEATS][N];
  logic [N*OUT_W-1:0] obs_data  [BEATS];
  logic [EXP_W-1:0]   obs_exp   [BEATS];
  logic               obs_first [BEATS];
  logic               obs_last  [BEATS];
  int  lat, hold_err, sready_err, extra_valid, n_checks, n_fail;
  bit  timeout, post_valid, post_sready;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Largest shift that keeps x representable in IN_W signed bits.
  function automatic int model_rsb(longint x);
    longint v;
    longint lim;
    lim = longint'(1) <<< (IN_W - 1);
    for (int k = IN_W - 1; k >= 0; k--) begin
      v = x * (longint'(1) <<< k);
      if (v >= -lim && v <= lim - 1) return k;
    end
    return 0;
  endfunction

  function automatic int model_exp();
    int e;
    e = IN_W - 1;
    for (int b = 0; b < BEATS; b++)
      for (int i = 0; i < N; i++)
        if (model_rsb(stim[b][i]) < e) e = model_rsb(stim[b][i]);
    return e;
  endfunction

  function automatic longint model_out(longint x, int e);
    longint t, q;
    t = x * (longint'(1) <<< e);
`ifdef CBFP_ROUND_EN
    q = (t + (longint'(1) <<< (SH - 1))) >>> SH;
    if (q > (longint'(1) <<< (OUT_W - 1)) - 1) q = (longint'(1) <<< (OUT_W - 1)) - 1;
    if (q < -(longint'(1) <<< (OUT_W - 1)))    q = -(longint'(1) <<< (OUT_W - 1));
`else
    q = t >>> SH;
`endif
    return q;
  endfunction

  function automatic longint got_sample(int b, int i);
    logic signed [OUT_W-1:0] sv;
    sv = obs_data[b][i*OUT_W +: OUT_W];
    return longint'(sv);
  endfunction

  task automatic clear_stim();
    for (int b = 0; b < BEATS; b++)
      for (int i = 0; i < N; i++) stim[b][i] = 0;
  endtask

  // Samples up to maxmag bits wide, with a sprinkling of zeros.
  task automatic gen_random_block(int maxmag);
    int     mag;
    longint x;
    for (int b = 0; b < BEATS; b++)
      for (int i = 0; i < N; i++) begin
        mag = $urandom_range(1, maxmag);
        x   = longint'($urandom) & ((longint'(1) <<< mag) - 1);
        if (x >= (longint'(1) <<< (mag - 1))) x = x - (longint'(1) <<< mag);
        stim[b][i] = ($urandom_range(0, 7) == 0) ? 0 : x;
      end
  endtask

  task automatic drive_beat(int b);
    bus.s_valid = 1'b1;
    for (int i = 0; i < N; i++) bus.s_data[i*IN_W +: IN_W] = stim[b][i][IN_W-1:0];
  endtask

  // Feeds stim as one block, then drains it: mode 0 always ready, 1 ready 1,0,0,1, 2 random.
  task automatic run_block(int mode, bit hold_valid, int idle);
    bit pat [4];
    bit r, stalled, first_seen;
    int guard, got, accept_cyc, pidx;
    logic [N*OUT_W-1:0] snap_data;
    logic [EXP_W-1:0]   snap_exp;
    logic               snap_first, snap_last;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    timeout = 0; hold_err = 0; sready_err = 0; extra_valid = 0; lat = -1;
    accept_cyc = cyc;
    bus.m_ready = 1'b1;
    for (int b = 0; b < BEATS; b++) begin
      drive_beat(b);
      guard = 0;
      while (!bus.s_ready && guard < 50) begin tick(); guard++; end
      if (guard >= 50) timeout = 1;
      tick();
      accept_cyc = cyc;
    end
    if (hold_valid) begin
      for (int i = 0; i < N; i++) bus.s_data[i*IN_W +: IN_W] = IN_W'($urandom);
    end else begin
      bus.s_valid = 1'b0;
    end
    got = 0; guard = 0; stalled = 0; first_seen = 0; pidx = 0;
    snap_data = '0; snap_exp = '0; snap_first = 0; snap_last = 0;
    while (got < BEATS && guard < 300) begin
      if (bus.m_valid && !first_seen) begin first_seen = 1; lat = cyc - accept_cyc + 1; end
      if (stalled && (!bus.m_valid || bus.m_data !== snap_data || bus.m_exp !== snap_exp ||
                      bus.m_first !== snap_first || bus.m_last !== snap_last)) hold_err++;
      if (bus.s_ready) sready_err++;
      case (mode)
        1:       r = pat[pidx % 4];
        2:       r = $urandom_range(0, 1) == 1;
        default: r = 1'b1;
      endcase
      if (bus.m_valid) pidx++;
      bus.m_ready = r;
      if (bus.m_valid && r) begin
        obs_data[got] = bus.m_data;  obs_exp[got]  = bus.m_exp;
        obs_first[got] = bus.m_first; obs_last[got] = bus.m_last;
        got++;
      end
      stalled = bus.m_valid && !r;
      snap_data = bus.m_data; snap_exp = bus.m_exp; snap_first = bus.m_first; snap_last = bus.m_last;
      tick();
      guard++;
    end
    if (got < BEATS) timeout = 1;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    post_valid  = bus.m_valid;
    post_sready = bus.s_ready;
    for (int k = 0; k < idle; k++) begin
      tick();
      if (bus.m_valid) extra_valid++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_checks += 6;
    if (bus.s_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_s_ready: got %b, want 1", bus.s_ready); end
    if (bus.m_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_m_valid: got %b, want 0", bus.m_valid); end
    if (bus.m_first !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_m_first: got %b, want 0", bus.m_first); end
    if (bus.m_last !== 1'b0)  begin n_fail++; $display("[TB] FAIL reset_m_last: got %b, want 0", bus.m_last); end
    if (bus.m_exp !== '0)     begin n_fail++; $display("[TB] FAIL reset_m_exp: got %0d, want 0", bus.m_exp); end
    if (bus.m_data !== '0)    begin n_fail++; $display("[TB] FAIL reset_m_data: got %h, want 0", bus.m_data); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_sample();
    int pb, pi, e;
    clear_stim();
    pb = $urandom_range(0, BEATS - 1);
    pi = $urandom_range(0, N - 1);
    stim[pb][pi] = 1000;
    e = model_exp();
    run_block(0, 0, 2);
    n_checks += 4;
    if (e != 14)   begin n_fail++; $display("[TB] FAIL t1_model_exp: got %0d, want 14", e); end
    if (lat != LAT) begin n_fail++; $display("[TB] FAIL t1_latency: got %0d edges, want %0d", lat, LAT); end
    if (timeout)   begin n_fail++; $display("[TB] FAIL t1_timeout: got timeout, want %0d beats", BEATS); end
    if (got_sample(pb, pi) != 2000) begin n_fail++; $display("[TB] FAIL t1_sample: got %0d, want 2000", got_sample(pb, pi)); end
    for (int b = 0; b < BEATS; b++) begin
      n_checks += 3;
      if (obs_exp[b] !== EXP_W'(14)) begin n_fail++; $display("[TB] FAIL t1_exp b%0d: got %0d, want 14", b, obs_exp[b]); end
      if (obs_first[b] !== (b == 0)) begin n_fail++; $display("[TB] FAIL t1_first b%0d: got %b, want %b", b, obs_first[b], b == 0); end
      if (obs_last[b] !== (b == BEATS - 1)) begin n_fail++; $display("[TB] FAIL t1_last b%0d: got %b, want %b", b, obs_last[b], b == BEATS - 1); end
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (got_sample(b, i) != model_out(stim[b][i], 14)) begin
          n_fail++; $display("[TB] FAIL t1_data b%0d s%0d: got %0d, want %0d", b, i, got_sample(b, i), model_out(stim[b][i], 14));
        end
      end
    end
  endtask

  task automatic test_zero_block();
    clear_stim();
    run_block(0, 0, 4);
    n_checks += 4;
    if (timeout)           begin n_fail++; $display("[TB] FAIL t2_timeout: got timeout, want %0d beats", BEATS); end
    if (extra_valid != 0)  begin n_fail++; $display("[TB] FAIL t2_extra_beats: got %0d extra, want 0", extra_valid); end
    if (post_valid !== 1'b0)  begin n_fail++; $display("[TB] FAIL t2_post_valid: got %b, want 0", post_valid); end
    if (post_sready !== 1'b1) begin n_fail++; $display("[TB] FAIL t2_post_sready: got %b, want 1", post_sready); end
    for (int b = 0; b < BEATS; b++) begin
      n_checks += 2;
      if (obs_exp[b] !== EXP_W'(IN_W - 1)) begin n_fail++; $display("[TB] FAIL t2_exp b%0d: got %0d, want %0d", b, obs_exp[b], IN_W - 1); end
      if (obs_data[b] !== '0) begin n_fail++; $display("[TB] FAIL t2_data b%0d: got %h, want 0", b, obs_data[b]); end
    end
  endtask

  task automatic test_extremes();
    clear_stim();
    stim[0][0] = (longint'(1) <<< (IN_W - 1)) - 1;
    stim[BEATS-1][5] = -(longint'(1) <<< (IN_W - 1));
    stim[1][3] = -1;
    run_block(0, 0, 1);
    n_checks += 4;
    if (timeout) begin n_fail++; $display("[TB] FAIL t3_timeout: got timeout, want %0d beats", BEATS); end
    if (obs_exp[0] !== '0) begin n_fail++; $display("[TB] FAIL t3_exp: got %0d, want 0", obs_exp[0]); end
    if (got_sample(0, 0) != 2047) begin n_fail++; $display("[TB] FAIL t3_max: got %0d, want 2047", got_sample(0, 0)); end
    if (got_sample(BEATS-1, 5) != -2048) begin n_fail++; $display("[TB] FAIL t3_min: got %0d, want -2048", got_sample(BEATS-1, 5)); end
    for (int b = 0; b < BEATS; b++)
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (got_sample(b, i) != model_out(stim[b][i], 0)) begin
          n_fail++; $display("[TB] FAIL t3_data b%0d s%0d: got %0d, want %0d", b, i, got_sample(b, i), model_out(stim[b][i], 0));
        end
      end
  endtask

  task automatic test_backpressure();
    int e;
    gen_random_block(16);
    e = model_exp();
    run_block(1, 1, 1);
    n_checks += 4;
    if (timeout)         begin n_fail++; $display("[TB] FAIL t4_timeout: got timeout, want %0d beats", BEATS); end
    if (hold_err != 0)   begin n_fail++; $display("[TB] FAIL t4_hold: got %0d changes while stalled, want 0", hold_err); end
    if (sready_err != 0) begin n_fail++; $display("[TB] FAIL t4_s_ready: got %0d cycles high while draining, want 0", sready_err); end
    if (post_sready !== 1'b1) begin n_fail++; $display("[TB] FAIL t4_post_sready: got %b, want 1", post_sready); end
    for (int b = 0; b < BEATS; b++) begin
      n_checks++;
      if (obs_exp[b] !== EXP_W'(e)) begin n_fail++; $display("[TB] FAIL t4_exp b%0d: got %0d, want %0d", b, obs_exp[b], e); end
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (got_sample(b, i) != model_out(stim[b][i], e)) begin
          n_fail++; $display("[TB] FAIL t4_data b%0d s%0d: got %0d, want %0d", b, i, got_sample(b, i), model_out(stim[b][i], e));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int exps [2];
    for (int k = 0; k < 2; k++) begin
      gen_random_block(k == 0 ? 13 : 3);
      for (int b = 0; b < BEATS; b++)
        for (int i = 0; i < N; i++) begin
          if (k == 0 && (stim[b][i] > 4095 || stim[b][i] < -4095)) stim[b][i] = 4095;
          if (k == 1 && stim[b][i] < -3) stim[b][i] = -3;
        end
      stim[$urandom_range(0, BEATS - 1)][$urandom_range(0, N - 1)] = (k == 0) ? 4095 : 3;
      exps[k] = (k == 0) ? 12 : 22;
      run_block(0, 0, 0);
      n_checks++;
      if (timeout) begin n_fail++; $display("[TB] FAIL t5_timeout blk%0d: got timeout, want %0d beats", k, BEATS); end
      for (int b = 0; b < BEATS; b++) begin
        n_checks++;
        if (obs_exp[b] !== EXP_W'(exps[k])) begin n_fail++; $display("[TB] FAIL t5_exp blk%0d b%0d: got %0d, want %0d", k, b, obs_exp[b], exps[k]); end
        for (int i = 0; i < N; i++) begin
          n_checks++;
          if (got_sample(b, i) != model_out(stim[b][i], exps[k])) begin
            n_fail++; $display("[TB] FAIL t5_data blk%0d b%0d s%0d: got %0d, want %0d", k, b, i, got_sample(b, i), model_out(stim[b][i], exps[k]));
          end
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int e;
    clear_stim();
    gen_random_block(13);
    stim[0][0] = 4095;
    for (int b = 0; b < 3; b++) begin
      drive_beat(b);
      tick();
    end
    bus.s_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks += 2;
    if (bus.m_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL t6_m_valid: got %b, want 0", bus.m_valid); end
    if (bus.s_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL t6_s_ready: got %b, want 1", bus.s_ready); end
    gen_random_block(3);
    stim[BEATS-1][N-1] = 3;
    for (int b = 0; b < BEATS; b++)
      for (int i = 0; i < N; i++) if (stim[b][i] < -3) stim[b][i] = -3;
    e = model_exp();
    run_block(0, 0, 1);
    n_checks += 2;
    if (timeout) begin n_fail++; $display("[TB] FAIL t6_timeout: got timeout, want %0d beats", BEATS); end
    if (lat != LAT) begin n_fail++; $display("[TB] FAIL t6_latency: got %0d edges, want %0d", lat, LAT); end
    for (int b = 0; b < BEATS; b++) begin
      n_checks++;
      if (obs_exp[b] !== EXP_W'(e)) begin n_fail++; $display("[TB] FAIL t6_exp b%0d: got %0d, want %0d", b, obs_exp[b], e); end
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (got_sample(b, i) != model_out(stim[b][i], e)) begin
          n_fail++; $display("[TB] FAIL t6_data b%0d s%0d: got %0d, want %0d", b, i, got_sample(b, i), model_out(stim[b][i], e));
        end
      end
    end
  endtask

  task automatic test_random();
    int e;
    for (int k = 0; k < 6; k++) begin
      gen_random_block($urandom_range(1, IN_W));
      e = model_exp();
      run_block(2, k[0], $urandom_range(0, 2));
      n_checks += 2;
      if (timeout)       begin n_fail++; $display("[TB] FAIL rnd_timeout blk%0d: got timeout, want %0d beats", k, BEATS); end
      if (hold_err != 0) begin n_fail++; $display("[TB] FAIL rnd_hold blk%0d: got %0d changes while stalled, want 0", k, hold_err); end
      for (int b = 0; b < BEATS; b++) begin
        n_checks += 3;
        if (obs_exp[b] !== EXP_W'(e)) begin n_fail++; $display("[TB] FAIL rnd_exp blk%0d b%0d: got %0d, want %0d", k, b, obs_exp[b], e); end
        if (obs_first[b] !== (b == 0)) begin n_fail++; $display("[TB] FAIL rnd_first blk%0d b%0d: got %b, want %b", k, b, obs_first[b], b == 0); end
        if (obs_last[b] !== (b == BEATS - 1)) begin n_fail++; $display("[TB] FAIL rnd_last blk%0d b%0d: got %b, want %b", k, b, obs_last[b], b == BEATS - 1); end
        for (int i = 0; i < N; i++) begin
          n_checks++;
          if (got_sample(b, i) != model_out(stim[b][i], e)) begin
            n_fail++; $display("[TB] FAIL rnd_data blk%0d b%0d s%0d: got %0d, want %0d", k, b, i, got_sample(b, i), model_out(stim[b][i], e));
          end
        end
      end
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
    $display("[TB] cbfp_block_scaler bench start");
    test_reset();
    test_single_sample();
    test_zero_block();
    test_extremes();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
